// File: rtl/demod_pkg.sv
// Shared types and Q10 fixed-point helpers for the FM demodulator sequencer.
package demod_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MULT  = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      SCALE = 3'd4,
      WRITE = 3'd5
   } state_t;

   localparam int              BITS      = 10;
   localparam logic [31:0]     QUANT_ONE = 32'h0000_0400;
   localparam int              PROD_W    = 64;
   localparam logic signed [PROD_W-1:0] SAT_MAX = 64'sd32767;
   localparam logic signed [PROD_W-1:0] SAT_MIN = -64'sd32768;

   // Full-width signed product shifted back to Q format; caller truncates to its sample width.
   function automatic logic signed [PROD_W-1:0] dequantize(
      input logic signed [PROD_W-1:0] a,
      input logic signed [PROD_W-1:0] b,
      input int                       shift
   );
      return (a * b) >>> shift;
   endfunction

endpackage

// File: rtl/demod_sequencer.sv
// Per-sample FM demod controller: pop I/Q, conjugate product, arctan handshake, gain, push.
// Latency: pop to push = 4 cycles + arctan start-to-done + output-full stall; one sample in flight.
// Backpressure: stalls in WRITE while out_full; pops only from IDLE. DEMOD_SAT_EN clamps output to 16 bits.
module demod_sequencer
   import demod_pkg::*;
#(
   parameter int                       DATA_WIDTH = 32,
   parameter int                       BITS       = 10,
   parameter logic signed [DATA_WIDTH-1:0] GAIN   = DATA_WIDTH'(QUANT_ONE)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_empty,
   output logic                         in_rd_en,
   input  logic signed [DATA_WIDTH-1:0] real_in,
   input  logic signed [DATA_WIDTH-1:0] imag_in,
   output logic                         atan_start,
   output logic signed [DATA_WIDTH-1:0] atan_x,
   output logic signed [DATA_WIDTH-1:0] atan_y,
   input  logic signed [DATA_WIDTH-1:0] atan_angle,
   input  logic                         atan_done,
   input  logic                         out_full,
   output logic                         out_wr_en,
   output logic signed [DATA_WIDTH-1:0] demod_out,
   output logic                         busy
);

   state_t state, state_nxt;

   logic signed [DATA_WIDTH-1:0] cur_r, cur_i;
   logic signed [DATA_WIDTH-1:0] prev_r, prev_i;
   logic signed [DATA_WIDTH-1:0] angle;
   logic signed [DATA_WIDTH-1:0] scaled, scaled_q, demod_held;

   function automatic logic signed [PROD_W-1:0] widen(input logic signed [DATA_WIDTH-1:0] v);
      return {{(PROD_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
   endfunction

`ifdef DEMOD_SAT_EN
   logic signed [PROD_W-1:0] scaled_full;

   always_comb begin
      scaled_full = dequantize(widen(angle), widen(GAIN), BITS);
      if (scaled_full > SAT_MAX)
         scaled = DATA_WIDTH'(SAT_MAX);
      else if (scaled_full < SAT_MIN)
         scaled = DATA_WIDTH'(SAT_MIN);
      else
         scaled = DATA_WIDTH'(scaled_full);
   end
`else
   assign scaled = DATA_WIDTH'(dequantize(widen(angle), widen(GAIN), BITS));
`endif

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_rd_en   = 1'b0;
      atan_start = 1'b0;
      out_wr_en  = 1'b0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (!in_empty) begin
               in_rd_en  = 1'b1;
               state_nxt = MULT;
            end
         end
         MULT:  state_nxt = START;
         START: begin
            atan_start = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            if (atan_done)
               state_nxt = SCALE;
         end
         SCALE: state_nxt = WRITE;
         WRITE: begin
            if (!out_full) begin
               out_wr_en = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Outputs read as zero for the whole reset cycle, whatever state is being cleared.
      if (reset) begin
         in_rd_en   = 1'b0;
         atan_start = 1'b0;
         out_wr_en  = 1'b0;
         busy       = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_r      <= '0;
         cur_i      <= '0;
         prev_r     <= '0;
         prev_i     <= '0;
         atan_x     <= '0;
         atan_y     <= '0;
         angle      <= '0;
         scaled_q   <= '0;
         demod_held <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!in_empty) begin
                  cur_r <= real_in;
                  cur_i <= imag_in;
               end
            end
            MULT: begin
               // x + jy = cur * conj(prev), computed at full width before requantizing.
               atan_x <= DATA_WIDTH'((widen(cur_r) * widen(prev_r) + widen(cur_i) * widen(prev_i)) >>> BITS);
               atan_y <= DATA_WIDTH'((widen(cur_i) * widen(prev_r) - widen(cur_r) * widen(prev_i)) >>> BITS);
               prev_r <= cur_r;
               prev_i <= cur_i;
            end
            WAIT: begin
               if (atan_done)
                  angle <= atan_angle;
            end
            SCALE: scaled_q <= scaled;
            WRITE: begin
               if (!out_full)
                  demod_held <= scaled_q;
            end
            default: ;
         endcase
      end
   end

   // Present the new value in the push cycle itself, then hold it until the next push.
   assign demod_out = out_wr_en ? scaled_q : demod_held;

endmodule

// File: tb/tb_demod_sequencer.sv
// Directed bench for demod_sequencer: three gain variants share stimulus and a 3-cycle arctan model.
module tb_demod_sequencer;

`ifdef DEMOD_SAT_EN
   localparam int S_P1608 = 32767;
   localparam int S_N1608 = -32768;
   localparam int S_P500  = 32767;
`else
   localparam int S_P1608 = 1646592;
   localparam int S_N1608 = -1646592;
   localparam int S_P500  = 512000;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic in_empty = 1'b1;
   logic out_full = 1'b0;
   logic signed [31:0] real_in = '0;
   logic signed [31:0] imag_in = '0;
   logic signed [31:0] atan_ret = '0;
   logic signed [31:0] atan_angle;
   logic model_done = 1'b0;
   logic man_done = 1'b0;
   logic atan_done;

   assign atan_angle = atan_ret;
   assign atan_done  = model_done | man_done;

   logic a_rd, a_st, a_wr, a_busy;
   logic h_rd, h_st, h_wr, h_busy;
   logic s_rd, s_st, s_wr, s_busy;
   logic signed [31:0] a_x, a_y, a_out;
   logic signed [31:0] h_x, h_y, h_out;
   logic signed [31:0] s_x, s_y, s_out;

   demod_sequencer #(.DATA_WIDTH(32), .BITS(10), .GAIN(32'h0000_0400)) dut (
      .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(a_rd),
      .real_in(real_in), .imag_in(imag_in), .atan_start(a_st), .atan_x(a_x), .atan_y(a_y),
      .atan_angle(atan_angle), .atan_done(atan_done), .out_full(out_full),
      .out_wr_en(a_wr), .demod_out(a_out), .busy(a_busy));

   demod_sequencer #(.DATA_WIDTH(32), .BITS(10), .GAIN(32'h0000_0200)) dut_half (
      .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(h_rd),
      .real_in(real_in), .imag_in(imag_in), .atan_start(h_st), .atan_x(h_x), .atan_y(h_y),
      .atan_angle(atan_angle), .atan_done(atan_done), .out_full(out_full),
      .out_wr_en(h_wr), .demod_out(h_out), .busy(h_busy));

   demod_sequencer #(.DATA_WIDTH(32), .BITS(10), .GAIN(32'h0010_0000)) dut_big (
      .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(s_rd),
      .real_in(real_in), .imag_in(imag_in), .atan_start(s_st), .atan_x(s_x), .atan_y(s_y),
      .atan_angle(atan_angle), .atan_done(atan_done), .out_full(out_full),
      .out_wr_en(s_wr), .demod_out(s_out), .busy(s_busy));

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int pushes = 0;
   int pops   = 0;
   int dly    = 0;

   logic signed [31:0] q_x[$], q_y[$], q_a[$], q_h[$], q_s[$];
   logic signed [31:0] ex, ey, eo;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Arctan model: done pulses three cycles after start is seen.
   always @(posedge clock) begin
      model_done <= 1'b0;
      if (dly > 0) begin
         dly <= dly - 1;
         if (dly == 1)
            model_done <= 1'b1;
      end
      if (a_st)
         dly <= 3;
   end

   always @(negedge clock) begin
      if (a_rd) pops++;
      if (a_st) begin
         checks++;
         assert (q_x.size() > 0) else begin
            errors++;
            $error("FAIL xy_unexpected: observed an atan_start expected none");
         end
         if (q_x.size() > 0) begin
            ex = q_x.pop_front();
            ey = q_y.pop_front();
            check("atan_x", a_x, ex);
            check("atan_y", a_y, ey);
            check("atan_x_big", s_x, ex);
         end
      end
      if (a_wr) begin
         pushes++;
         checks++;
         assert (q_a.size() > 0) else begin
            errors++;
            $error("FAIL push_unexpected: observed a push expected none");
         end
         if (q_a.size() > 0) begin
            eo = q_a.pop_front();
            check("demod_out_g1024", a_out, eo);
         end
      end
      if (h_wr && q_h.size() > 0) begin
         eo = q_h.pop_front();
         check("demod_out_g512", h_out, eo);
      end
      if (s_wr && q_s.size() > 0) begin
         eo = q_s.pop_front();
         check("demod_out_gbig", s_out, eo);
      end
   end

   task automatic expect_out(input int a, input int h, input int s);
      q_a.push_back(a);
      q_h.push_back(h);
      q_s.push_back(s);
   endtask

   task automatic send(input int r, input int i, input int exp_x, input int exp_y);
      int n;
      q_x.push_back(exp_x);
      q_y.push_back(exp_y);
      @(posedge clock);
      #1;
      real_in  = r;
      imag_in  = i;
      in_empty = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!a_rd && n < 50);
      check("pop_seen", a_rd, 1'b1);
      @(posedge clock);
      #1;
      in_empty = 1'b1;
   endtask

   task automatic wait_pushes(input int target);
      int n;
      n = 0;
      while (pushes < target && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("push_count", pushes, target);
   endtask

   initial begin
      int wr_seen, rd_seen, act_seen, n;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_in_rd_en", a_rd, 1'b0);
      check("rst_atan_start", a_st, 1'b0);
      check("rst_out_wr_en", a_wr, 1'b0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_atan_x", a_x, 0);
      check("rst_atan_y", a_y, 0);
      check("rst_demod_out", a_out, 0);
      @(posedge clock);
      #1 reset = 1'b0;

      // First sample meets prev = 0, so the product is zero.
      atan_ret = 1608;
      expect_out(1608, 804, S_P1608);
      send(1024, 0, 0, 0);
      wait_pushes(1);

      expect_out(1608, 804, S_P1608);
      send(0, 1024, 0, 1024);
      wait_pushes(2);

      atan_ret = -1608;
      expect_out(-1608, -804, S_N1608);
      send(2048, 1024, 1024, -2048);
      wait_pushes(3);
      @(negedge clock);
      check("busy_after_push", a_busy, 1'b0);

      // Output stall with new input waiting.
      out_full = 1'b1;
      atan_ret = 500;
      expect_out(500, 250, S_P500);
      send(1024, 1024, 3072, 1024);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!atan_done && n < 50);
      check("atan_done_seen", atan_done, 1'b1);
      @(negedge clock);
      @(posedge clock);
      #1;
      real_in  = 77;
      imag_in  = 33;
      in_empty = 1'b0;
      wr_seen = 0;
      rd_seen = 0;
      repeat (10) begin
         @(negedge clock);
         if (a_wr) wr_seen++;
         if (a_rd) rd_seen++;
      end
      check("stall_no_push", wr_seen, 0);
      check("stall_no_pop", rd_seen, 0);
      check("stall_busy", a_busy, 1'b1);
      @(posedge clock);
      #1;
      out_full = 1'b0;
      in_empty = 1'b1;
      wait_pushes(4);
      repeat (5) @(negedge clock);
      check("stall_single_push", pushes, 4);
      check("stall_back_idle", a_busy, 1'b0);

      // Abort in WAIT; the late done lands in IDLE and must be ignored.
      atan_ret = 1608;
      send(3000, -500, 2500, -3500);
      @(negedge clock);
      @(negedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("abort_busy", a_busy, 1'b0);
      check("abort_atan_x", a_x, 0);
      check("abort_atan_y", a_y, 0);
      act_seen = 0;
      n = 0;
      repeat (10) begin
         @(negedge clock);
         if (atan_done) n++;
         if (a_wr || a_busy) act_seen++;
      end
      check("abort_done_arrived", n, 1);
      check("abort_no_activity", act_seen, 0);
      check("abort_push_count", pushes, 4);

      expect_out(1608, 804, S_P1608);
      send(100, 200, 0, 0);
      wait_pushes(5);

      // Stray done while idle with nothing to pop.
      repeat (2) @(posedge clock);
      #1 man_done = 1'b1;
      @(posedge clock);
      #1 man_done = 1'b0;
      act_seen = 0;
      repeat (5) begin
         @(negedge clock);
         if (a_busy || a_rd || a_st || a_wr) act_seen++;
      end
      check("idle_done_ignored", act_seen, 0);

      // Negative sum exercises floor behaviour of the arithmetic shift.
      atan_ret = -1608;
      expect_out(-1608, -804, S_N1608);
      send(-300, 50, -20, 63);
      wait_pushes(6);

      repeat (3) @(negedge clock);
      check("total_pops", pops, 7);
      check("q_xy_drained", q_x.size(), 0);
      check("q_g1024_drained", q_a.size(), 0);
      check("q_g512_drained", q_h.size(), 0);
      check("q_gbig_drained", q_s.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
